lock_enable_gen: RTL and testbench
==================================

Name: lock_enable_gen

Overview:
- Upstream qualifier for the LED blinker.
- Takes the raw PLL lock flag from the MSS block (PLL_CPU_LOCK_M2F), which is asynchronous to the fabric clock.
- Synchronises it into the fabric clock domain, requires it to stay stable before releasing enable, and holds enable off for a back-off period after any lock loss.
- Its enable output drives the blinker's enable input directly. It also counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on lock_in (legal range ≥2).
- STABLE_CYCLES, 16000, consecutive synchronised-high cycles required before enable asserts (≥1; 100 us at 160 MHz).
- BACKOFF_CYCLES, 1600, cycles enable is held low after a lock loss before requalifying (≥1).
- LOSS_CNT_W, 8, width of the lock-loss counter.

Ports:
- clkin  input  1  fabric clock (CCC OUT0_FABCLK_0).
- reset  input  1  synchronous, active-high reset.
- lock_in  input  1  raw PLL lock, asynchronous to clkin.
- enable  output  1  qualified enable to the blinker; registered.
- locked_sync  output  1  synchronised lock_in (last synchroniser stage).
- lock_loss_count  output  LOSS_CNT_W  saturating count of RUN→BACKOFF transitions.
- state  output  2  FSM state for debug: 00 WAIT_LOCK, 01 QUALIFY, 10 RUN, 11 BACKOFF.

Behaviour:
- One clock (clkin). Reset is synchronous and active-high. All flops update on the rising edge of clkin.
- Reset:
  - Synchroniser flops = 0, state = WAIT_LOCK, internal counter = 0.
  - enable = 0, locked_sync = 0, lock_loss_count = 0.
  - Reset has priority over every other event, including reset asserted mid-RUN: enable = 0 on the first edge with reset high.
- Synchroniser: lock_in passes through SYNC_STAGES flops; lock_s = last stage = locked_sync. No other logic samples lock_in.
- Internal counter width: clog2(max(STABLE_CYCLES, BACKOFF_CYCLES)) + 1.
- WAIT_LOCK: counter held at 0. lock_s = 1 → QUALIFY with counter = 0.
- QUALIFY:
  - lock_s = 0 → WAIT_LOCK. Counter cleared; lock_loss_count unchanged (a glitch is not a loss).
  - lock_s = 1 and counter < STABLE_CYCLES-1 → counter+1.
  - lock_s = 1 and counter = STABLE_CYCLES-1 → RUN. QUALIFY therefore lasts exactly STABLE_CYCLES cycles.
- RUN:
  - enable = 1. enable is a registered decode of the next state, so enable is high in the same cycle state reads RUN.
  - lock_s = 0 → BACKOFF with counter = 0, and lock_loss_count+1, saturating at all-ones (no wrap).
- BACKOFF:
  - enable = 0. The counter increments every cycle regardless of lock_s.
  - counter = BACKOFF_CYCLES-1 → WAIT_LOCK.
  - Lock returning during BACKOFF does not shorten it.
- Latency:
  - Lock rising: enable rises SYNC_STAGES + STABLE_CYCLES + 1 edges after the first edge that samples lock_in = 1.
  - Lock falling: enable falls SYNC_STAGES + 1 edges after the first edge that samples lock_in = 0.
- enable never glitches. It is asserted only while state = RUN.
- Minimum enable-low time after any loss: BACKOFF_CYCLES + STABLE_CYCLES + 1 cycles.

Test Plan:
- Use SYNC_STAGES=2, STABLE_CYCLES=8, BACKOFF_CYCLES=4, LOSS_CNT_W=2 unless stated.
- Reset, then lock_in=0 for 50 cycles → enable=0, state=00, lock_loss_count=0 throughout.
- lock_in rises and stays high → locked_sync high after 2 edges; state=01 for exactly 8 cycles; enable=1 and state=10 on edge 11 after the first sampled high.
- In QUALIFY, drop lock_in for 1 cycle at qualify count 5 → state returns to 00, count restarts, enable stays 0, lock_loss_count stays 0; enable asserts 11 edges after lock is restored.
- In RUN, drop lock_in → enable=0 three edges later, state=11 for 4 cycles even with lock_in re-raised immediately, then 00→01→10; lock_loss_count=1.
- Cause 5 RUN losses → lock_loss_count reads 1, 2, 3, 3, 3 (saturates, no wrap).
- Assert reset for 1 cycle during RUN → enable=0, state=00, lock_loss_count=0 on that edge; with lock_in still high, enable reasserts 11 edges after reset deasserts.

Source files
------------

// File: rtl/lock_enable_gen.sv
// PLL lock qualifier: synchronises the raw lock flag, requires it to stay stable before
// enabling the LED blinker, and enforces a back-off period after every lock loss.
module lock_enable_gen #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 16000,
  parameter int unsigned BACKOFF_CYCLES = 1600,
  parameter int unsigned LOSS_CNT_W     = 8
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  lock_in,
  output logic                  enable,
  output logic                  locked_sync,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic [1:0]            state
);

  localparam int unsigned MaxCycles =
      (STABLE_CYCLES > BACKOFF_CYCLES) ? STABLE_CYCLES : BACKOFF_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] BackoffLast = CntW'(BACKOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'b00,
    StQualify  = 2'b01,
    StRun      = 2'b10,
    StBackoff  = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   enable_q, enable_d;
  logic                   lock_s;

  // lock_in is asynchronous; only the first synchroniser flop may sample it.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], lock_in};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = StQualify;
        end
      end
      StQualify: begin
        if (!lock_s) begin
          // A glitch while qualifying restarts qualification but is not a loss.
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = StBackoff;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
      end
      StBackoff: begin
        // Back-off always runs to completion, even if lock returns.
        if (cnt_q == BackoffLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered decode of the next state keeps enable glitch-free and aligned with RUN.
  assign enable_d = (state_d == StRun);

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= StWaitLock;
      cnt_q    <= '0;
      loss_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      enable_q <= enable_d;
    end
  end

  assign enable          = enable_q;
  assign locked_sync     = lock_s;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_lock_enable_gen.sv
// Randomised bench for lock_enable_gen against a countdown/run-length reference model,
// plus directed latency and saturation checks.
module tb_lock_enable_gen;

  localparam int unsigned SyncStages    = 2;
  localparam int unsigned StableCycles  = 8;
  localparam int unsigned BackoffCycles = 4;
  localparam int unsigned LossCntW      = 2;
  localparam int          LossMax       = (1 << LossCntW) - 1;

  logic                clkin;
  logic                reset;
  logic                lock_in;
  logic                enable;
  logic                locked_sync;
  logic [LossCntW-1:0] lock_loss_count;
  logic [1:0]          state;

  lock_enable_gen #(
    .SYNC_STAGES   (SyncStages),
    .STABLE_CYCLES (StableCycles),
    .BACKOFF_CYCLES(BackoffCycles),
    .LOSS_CNT_W    (LossCntW)
  ) u_dut (
    .clkin          (clkin),
    .reset          (reset),
    .lock_in        (lock_in),
    .enable         (enable),
    .locked_sync    (locked_sync),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: delay queue for the synchroniser, then plain counters:
  // m_qual = consecutive qualified-high edges, m_backoff = edges of back-off remaining.
  logic pipe[$];
  bit   m_run;
  int   m_backoff;
  int   m_qual;
  int   m_loss;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < SyncStages; i++) pipe.push_back(1'b0);
    m_run     = 1'b0;
    m_backoff = 0;
    m_qual    = 0;
    m_loss    = 0;
  endtask

  function automatic int exp_state();
    if (m_run) return 2;
    if (m_backoff > 0) return 3;
    if (m_qual > 0) return 1;
    return 0;
  endfunction

  // One clock edge with the given inputs; model and DUT are compared #1 after the edge.
  task automatic step(input logic l, input logic r);
    logic ls;
    lock_in = l;
    reset   = r;
    @(posedge clkin);
    if (r) begin
      model_reset();
    end else begin
      ls = pipe[0];
      pipe.push_back(l);
      void'(pipe.pop_front());
      if (m_run) begin
        if (!ls) begin
          m_run     = 1'b0;
          m_backoff = BackoffCycles;
          m_qual    = 0;
          if (m_loss < LossMax) m_loss++;
        end
      end else if (m_backoff > 0) begin
        m_backoff--;
      end else if (ls) begin
        m_qual++;
        if (m_qual == StableCycles + 1) begin
          m_run  = 1'b1;
          m_qual = 0;
        end
      end else begin
        m_qual = 0;
      end
    end
    #1;
    check("enable", int'(enable), int'(m_run));
    check("locked_sync", int'(locked_sync), int'(pipe[0]));
    check("state", int'(state), exp_state());
    check("loss_count", int'(lock_loss_count), m_loss);
  endtask

  task automatic hold(input logic l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  int lat;
  int seg_len;
  logic seg_val;
  int exp_loss[5] = '{1, 2, 3, 3, 3};

  initial begin
    lock_in = 1'b0;
    reset   = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    hold(1'b0, 50);

    // Rising latency: count edges from the first one sampling lock_in high.
    lat = 0;
    while (enable !== 1'b1 && lat < 40) begin
      step(1'b1, 1'b0);
      lat++;
    end
    check("rise_latency", lat, SyncStages + StableCycles + 1);
    hold(1'b1, 5);

    // Falling latency.
    lat = 0;
    while (enable !== 1'b0 && lat < 40) begin
      step(1'b0, 1'b0);
      lat++;
    end
    check("fall_latency", lat, SyncStages + 1);
    hold(1'b1, 20);

    // Glitch during qualification, after reset.
    step(1'b0, 1'b1);
    hold(1'b0, 5);
    hold(1'b1, SyncStages + 1 + 5);
    hold(1'b0, 1);
    hold(1'b1, 20);

    // Loss with lock re-raised immediately, then saturation of the loss counter.
    step(1'b0, 1'b1);
    hold(1'b1, 16);
    for (int k = 0; k < 5; k++) begin
      hold(1'b0, 1);
      hold(1'b1, 20);
      check("loss_sat", int'(lock_loss_count), exp_loss[k]);
    end

    // Reset pulse while in RUN with lock held high.
    step(1'b1, 1'b1);
    check("reset_enable", int'(enable), 0);
    hold(1'b1, 15);

    // Random lock waveforms with occasional resets.
    for (int s = 0; s < 300; s++) begin
      seg_val = 1'($urandom_range(0, 1));
      seg_len = int'($urandom_range(1, 25));
      for (int i = 0; i < seg_len; i++) begin
        step(seg_val, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
